// File: rtl/credit_tx_stage_if.sv
// Link-side bundle for credit_tx_stage: upstream FIFO head, link control,
// and the registered flit/credit status returned to the environment.
interface credit_tx_stage_if #(
    parameter int WordWidth = 64,
    parameter int CreditNum = 4
);
    localparam int CntWidth = $clog2(CreditNum + 1);

    logic                 fifo_empty_i;
    logic [WordWidth-1:0] fifo_payload_i;
    logic                 fifo_pop_o;
    logic                 link_en_i;
    logic                 flush_i;
    logic                 credit_return_i;
    logic                 tx_valid_o;
    logic [WordWidth-1:0] tx_payload_o;
    logic [CntWidth-1:0]  credit_cnt_o;
    logic                 idle_o;
    logic                 credit_overflow_o;

    // The stage itself.
    modport master (
        input  fifo_empty_i, fifo_payload_i, link_en_i, flush_i, credit_return_i,
        output fifo_pop_o, tx_valid_o, tx_payload_o, credit_cnt_o, idle_o,
        credit_overflow_o
    );

    // The surrounding FIFO, link controller and receiver.
    modport slave (
        output fifo_empty_i, fifo_payload_i, link_en_i, flush_i, credit_return_i,
        input  fifo_pop_o, tx_valid_o, tx_payload_o, credit_cnt_o, idle_o,
        credit_overflow_o
    );
endinterface

// File: rtl/credit_tx_stage.sv
// Credit-based transmit stage: pops the upstream FIFO only while the receiver
// has buffer space, registers each flit onto the link, and tracks credits.
module credit_tx_stage #(
    parameter int WordWidth = 64,
    parameter int CreditNum = 4,
    localparam int CntWidth = $clog2(CreditNum + 1)
) (
    input  logic clk,
    input  logic rstn,
    credit_tx_stage_if.master bus
);
    localparam logic [1:0] ST_DISABLED = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_DRAIN    = 2'd2;

    localparam logic [CntWidth-1:0] CreditMax = CntWidth'(CreditNum);

    logic [1:0]           state_q, state_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [WordWidth-1:0] tx_payload_q, tx_payload_d;
    logic [CntWidth-1:0]  credit_cnt_q, credit_cnt_d;
    logic                 overflow_q, overflow_d;
    logic                 pop;
    logic [CntWidth:0]    cnt_sum;

    // Registered count only: a credit arriving this cycle cannot fund a pop.
    always_comb begin
        pop = (state_q == ST_RUN) & ~bus.fifo_empty_i & (credit_cnt_q != '0) & ~bus.flush_i;
    end

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_sum      = {1'b0, credit_cnt_q} - {{CntWidth{1'b0}}, pop}
                     + {{CntWidth{1'b0}}, bus.credit_return_i};
        credit_cnt_d = cnt_sum[CntWidth-1:0];
        overflow_d   = overflow_q;
        if (cnt_sum > {1'b0, CreditMax}) begin
            credit_cnt_d = CreditMax;
            overflow_d   = 1'b1;
        end
    end

    always_comb begin
        tx_valid_d   = pop;
        tx_payload_d = pop ? bus.fifo_payload_i : tx_payload_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DISABLED: if (bus.link_en_i) state_d = ST_RUN;
            ST_RUN:      if (!bus.link_en_i) state_d = ST_DRAIN;
            ST_DRAIN: begin
                // Re-enable wins over completing the drain.
                if (bus.link_en_i) begin
                    state_d = ST_RUN;
                end else if ((credit_cnt_q == CreditMax) && !tx_valid_q) begin
                    state_d = ST_DISABLED;
                end
            end
            default:     state_d = ST_DISABLED;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its peers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_DISABLED;
            tx_valid_q   <= 1'b0;
            tx_payload_q <= '0;
            credit_cnt_q <= CreditMax;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_valid_q   <= tx_valid_d;
            tx_payload_q <= tx_payload_d;
            credit_cnt_q <= credit_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.fifo_pop_o        = pop;
    assign bus.tx_valid_o        = tx_valid_q;
    assign bus.tx_payload_o      = tx_payload_q;
    assign bus.credit_cnt_o      = credit_cnt_q;
    assign bus.idle_o            = (state_q == ST_DISABLED);
    assign bus.credit_overflow_o = overflow_q;
endmodule

// File: doc/credit_tx_stage.md
CREDIT_TX_STAGE -- requirements
Module: credit_tx_stage

Interface
REQ-001 SHALL have parameter WordWidth, default 64, payload width in bits.
REQ-002 SHALL have parameter CreditNum, default 4, receiver buffer depth and initial credit count (range 1..255).
REQ-003 SHALL define CntWidth = $clog2(CreditNum+1) for all credit-count signals.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 fifo_empty_i  input  1  upstream FIFO empty.
REQ-007 fifo_payload_i  input  WordWidth  upstream FIFO head entry.
REQ-008 fifo_pop_o  output  1  pop strobe to upstream FIFO.
REQ-009 link_en_i  input  1  level; link enable request.
REQ-010 flush_i  input  1  pulse; drop the flit in the output register.
REQ-011 credit_return_i  input  1  pulse; one credit returned by the receiver.
REQ-012 tx_valid_o  output  1  flit valid on link, registered.
REQ-013 tx_payload_o  output  WordWidth  flit payload, registered.
REQ-014 credit_cnt_o  output  CntWidth  current credit count, registered.
REQ-015 idle_o  output  1  high in state DISABLED.
REQ-016 credit_overflow_o  output  1  sticky error: credit returned while the count is already CreditNum.

Function
REQ-017 SHALL implement FSM states DISABLED, RUN, DRAIN.
REQ-018 DISABLED -> RUN when link_en_i=1; otherwise hold.
REQ-019 RUN -> DRAIN when link_en_i=0; otherwise hold.
REQ-020 DRAIN -> DISABLED when credit_cnt_o==CreditNum and tx_valid_o==0; DRAIN -> RUN if link_en_i=1 before that.
REQ-021 fifo_pop_o SHALL be combinational = (state==RUN) & ~fifo_empty_i & (credit_cnt_o!=0) & ~flush_i.
REQ-022 A credit_return_i pulse SHALL NOT enable a pop in the same cycle; there is no credit bypass.
REQ-023 On a cycle with fifo_pop_o=1, tx_payload_o <= fifo_payload_i and tx_valid_o <= 1 at the next edge; latency is exactly 1 cycle.
REQ-024 On a cycle with fifo_pop_o=0, tx_valid_o <= 0 and tx_payload_o holds its value.
REQ-025 On flush_i=1, tx_valid_o <= 0 at the next edge; state and credit count are unaffected by the flush itself.
REQ-026 credit_cnt next = cnt - fifo_pop_o + credit_return_i, computed in CntWidth+1 bits.
REQ-027 Pop and return in the same cycle SHALL leave the count unchanged.
REQ-028 If cnt==CreditNum and credit_return_i=1 with no pop: count SHALL saturate at CreditNum and credit_overflow_o SHALL set and remain set until reset.
REQ-029 The count SHALL never underflow; REQ-021 prevents a pop when cnt==0.
REQ-030 Back-to-back pops SHALL be sustained at one per cycle while credits remain; throughput is limited only by credits and FIFO occupancy.

Reset
REQ-031 While rstn=0, asynchronously: state=DISABLED, tx_valid_o=0, tx_payload_o=0, credit_cnt_o=CreditNum, idle_o=1, credit_overflow_o=0.
REQ-032 A reset asserted mid-transfer SHALL discard any in-flight flit; after release no flit is sent until link_en_i=1 is sampled.
REQ-033 fifo_pop_o SHALL be 0 throughout reset and in the first cycle after release, because the FSM is in DISABLED.

Verification
REQ-034 Reset, then link_en_i=1 with 6 FIFO entries A..F and CreditNum=4, no returns -> A,B,C,D sent on 4 consecutive cycles; credit_cnt_o reaches 0; no 5th pop.
REQ-035 From cnt=0, one credit_return_i pulse -> cnt=1 next cycle; E popped the cycle after; E on tx_payload_o one cycle later; cnt back to 0.
REQ-036 cnt=2 with a simultaneous pop and return for 3 cycles -> cnt stays 2; three flits sent.
REQ-037 cnt=4, idle FIFO, credit_return_i=1 -> cnt stays 4; credit_overflow_o=1 and held.
REQ-038 RUN with cnt=1, drop link_en_i -> DRAIN, no pops; return 3 credits -> DISABLED and idle_o=1 the cycle after cnt==4.
REQ-039 flush_i coincident with a non-empty FIFO -> fifo_pop_o=0 that cycle; tx_valid_o=0 next cycle; cnt unchanged.
